// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Multicycle signed multiply (radix-2 Booth) / divide (restoring)
//            unit producing HI/LO and a divide-by-zero flag.
//            Optional macro MULTDIV_FAST_ZERO_EN short-cuts zero operands.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             MultOrDiv,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Div0
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    // r_acc: Booth upper partial product (one guard bit) or division remainder
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic             r_qm1;
    logic             r_op;
    logic             r_sign_a;
    logic             r_sign_b;
    logic             r_dz;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_b_zero;
    logic             w_fast;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_booth;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_trial;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_b_zero = (B == '0);

`ifdef MULTDIV_FAST_ZERO_EN
    logic w_a_zero;
    assign w_a_zero = (A == '0);
    assign w_fast   = MultOrDiv ? (w_a_zero && !w_b_zero) : (w_a_zero || w_b_zero);
`else
    assign w_fast   = 1'b0;
`endif

    assign w_abs_a = A[WIDTH-1] ? -A : A;
    assign w_abs_b = B[WIDTH-1] ? -B : B;
    assign w_m_ext = {r_m[WIDTH-1], r_m};

    always_comb begin
        w_booth = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_booth = r_acc + w_m_ext;
            2'b10:   w_booth = r_acc - w_m_ext;
            default: w_booth = r_acc;
        endcase
    end

    // Remainder stays below the divisor magnitude, so the shifted value fits.
    assign w_div_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_m};
    assign w_quo_fix   = (r_sign_a ^ r_sign_b) ? -r_q : r_q;
    assign w_rem_fix   = r_sign_a ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if ((MultOrDiv && w_b_zero) || w_fast) w_next_state = S_FINISH;
                    else if (MultOrDiv)                    w_next_state = S_DIV;
                    else                                   w_next_state = S_MULT;
                end
            end
            S_MULT, S_DIV: begin
                if (r_cnt == c_LAST) w_next_state = S_FINISH;
            end
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_qm1    <= 1'b0;
            r_op     <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_dz     <= 1'b0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy   <= 1'b1;
                        r_div0   <= 1'b0;
                        r_cnt    <= '0;
                        r_op     <= MultOrDiv;
                        r_sign_a <= A[WIDTH-1];
                        r_sign_b <= B[WIDTH-1];
                        r_dz     <= MultOrDiv && w_b_zero;
                        r_zero   <= w_fast;
                        r_acc    <= '0;
                        r_qm1    <= 1'b0;
                        r_m      <= MultOrDiv ? w_abs_b : A;
                        r_q      <= MultOrDiv ? w_abs_a : B;
                    end
                end
                S_MULT: begin
                    r_acc <= {w_booth[WIDTH], w_booth[WIDTH:1]};
                    r_q   <= {w_booth[0], r_q[WIDTH-1:1]};
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    if (!w_div_trial[WIDTH]) begin
                        r_acc <= w_div_trial;
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc <= w_div_shift;
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FINISH: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    if (r_dz) begin
                        r_div0 <= 1'b1;
                    end else if (r_zero) begin
                        r_hi <= '0;
                        r_lo <= '0;
                    end else if (r_op) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= r_acc[WIDTH-1:0];
                        r_lo <= r_q;
                    end
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;
    assign Div0 = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// Testbench for mult_div_unit: scoreboard of expected HI/LO/Div0/done edge,
// checked by a monitor whenever done is observed.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        MultOrDiv = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Div0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .MultOrDiv (MultOrDiv),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .HI        (HI),
        .LO        (LO),
        .Div0      (Div0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          edge_n;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Drives start for one edge; call between a negedge and the next posedge.
    task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sbv, p, q, r;
        int     lat;
        logic   fast;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
`ifdef MULTDIV_FAST_ZERO_EN
        fast = op ? (a == 0 && b != 0) : (a == 0 || b == 0);
`else
        fast = 1'b0;
`endif
        lat  = 33;
        e.dz = 1'b0;
        if (!op) begin
            p    = sa * sbv;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 0) begin
            e.dz = 1'b1;
            e.hi = m_hi;
            e.lo = m_lo;
            lat  = 1;
        end else begin
            q    = sa / sbv;
            r    = sa % sbv;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        if (fast) lat = 1;
        start = 1'b1;
        MultOrDiv = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        e.edge_n = cyc + lat;
        sb.push_back(e);
        p_hi = m_hi;
        m_hi = e.hi;
        m_lo = e.lo;
        start = 1'b0;
        MultOrDiv = 1'($urandom);
        A = $urandom;
        B = $urandom;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("div0_cleared_at_start", 32'(Div0), 32'd0);
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) return;
            chk("busy_while_pending", 32'(busy), 32'd1);
            chk("hi_stable_mid_op", HI, p_hi);
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                me = sb.pop_front();
                chk("HI", HI, me.hi);
                chk("LO", LO, me.lo);
                chk("Div0", 32'(Div0), 32'(me.dz));
                chk("done_edge", cyc, me.edge_n);
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_div0", 32'(Div0), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        start_op(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done();
        start_op(1'b0, 32'h8000_0000, 32'h8000_0000);   // back-to-back in done cycle
        wait_done();
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();

        start_op(1'b0, 32'd3, 32'd5);
        wait_done();
        @(negedge clk);
        start_op(1'b1, 32'd5, 32'd0);
        wait_done();
        repeat (3) @(negedge clk);
        chk("div0_held", 32'(Div0), 32'd1);
        chk("done_is_pulse", 32'(done), 32'd0);
        start_op(1'b0, 32'd2, 32'hFFFF_FFFA);
        wait_done();

        @(negedge clk);
        start_op(1'b0, 32'd0, 32'd123);
        wait_done();
        start_op(1'b1, 32'd0, 32'hFFFF_FF85);
        wait_done();

        // extra start pulses while busy must be ignored
        @(negedge clk);
        start_op(1'b1, 32'd1000, 32'hFFFF_FFF9);
        repeat (5) @(negedge clk);
        start = 1'b1;
        MultOrDiv = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        for (int i = 0; i < 10; i++) begin
            logic        op;
            logic [31:0] a, b;
            op = 1'($urandom);
            a  = (i % 4 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom;
            start_op(op, a, b);
            wait_done();
        end

        // reset aborts mult at iteration 10
        @(negedge clk);
        start_op(1'b0, 32'h0123_4567, 32'h89AB_CDEF);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
